// File: rtl/systolic_output_deskew.sv
// systolic_output_deskew: realigns skewed systolic-array column results into one vector per enabled cycle
module systolic_output_deskew #(
  parameter int DATA_WIDTH = 32,
  parameter int SA_LENGTH  = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  sync_rst_i,
  input  logic                  en_i,
  input  logic                  in_valid_i,
  input  logic                  in_last_i,
  input  logic [DATA_WIDTH-1:0] inputs_i [0:SA_LENGTH-1],
  output logic [DATA_WIDTH-1:0] outputs_o [0:SA_LENGTH-1],
  output logic                  out_valid_o,
  output logic                  out_last_o,
  output logic [CNT_WIDTH-1:0]  vec_count_o
);
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  genvar c;
  generate
    for (c = 0; c < SA_LENGTH; c++) begin : g_col
      localparam int L = SA_LENGTH - 1 - c;
      if (L == 0) begin : g_pass
        assign outputs_o[c] = inputs_i[c];
      end else begin : g_dly
        // Chain shifts on every enabled cycle so bubbles travel with the data.
        logic [DATA_WIDTH-1:0] sr_q [0:L-1];
        always_ff @(posedge clk_i) begin
          if (sync_rst_i) begin
            for (int j = 0; j < L; j++) sr_q[j] <= '0;
          end else if (en_i) begin
            sr_q[0] <= inputs_i[c];
            for (int j = 1; j < L; j++) sr_q[j] <= sr_q[j-1];
          end
        end
        assign outputs_o[c] = sr_q[L-1];
      end
    end
    if (SA_LENGTH == 1) begin : g_vld_comb
      assign out_valid_o = in_valid_i;
      assign out_last_o  = in_valid_i & in_last_i;
    end else begin : g_vld_pipe
      logic [SA_LENGTH-2:0] vld_q, lst_q;
      always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
          vld_q <= '0;
          lst_q <= '0;
        end else if (en_i) begin
          vld_q[0] <= in_valid_i;
          lst_q[0] <= in_valid_i & in_last_i;
          for (int j = 1; j < SA_LENGTH - 1; j++) begin
            vld_q[j] <= vld_q[j-1];
            lst_q[j] <= lst_q[j-1];
          end
        end
      end
      assign out_valid_o = vld_q[SA_LENGTH-2];
      assign out_last_o  = lst_q[SA_LENGTH-2];
    end
  endgenerate
  always_comb cnt_d = (en_i && out_valid_o) ? (out_last_o ? '0 : cnt_q + 1'b1) : cnt_q;
  always_ff @(posedge clk_i) begin
    if (sync_rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign vec_count_o = cnt_q;
endmodule

// File: tb/tb_systolic_output_deskew.sv
// tb_systolic_output_deskew: directed + random stimulus against a history-based alignment model
module tb_systolic_output_deskew;
  logic clk = 0, rst = 0, en = 0, iv = 0, il = 0;
  logic [7:0] inp [0:3], outp [0:3], inp1 [0:0], outp1 [0:0];
  logic ov, ol, ov1, ol1;
  logic [3:0] cnt, cnt1;
  logic [7:0] din [0:3];
  logic [7:0] hd [0:1023][0:3];
  bit hv [0:1023], hl [0:1023];
  int t = 0, checks = 0, errs = 0;
  logic [3:0] mcnt = 0, mcnt1 = 0;

  always #5 clk = ~clk;

  systolic_output_deskew #(.DATA_WIDTH(8), .SA_LENGTH(4), .CNT_WIDTH(4)) dut (
    .clk_i(clk), .sync_rst_i(rst), .en_i(en), .in_valid_i(iv), .in_last_i(il),
    .inputs_i(inp), .outputs_o(outp), .out_valid_o(ov), .out_last_o(ol), .vec_count_o(cnt));

  systolic_output_deskew #(.DATA_WIDTH(8), .SA_LENGTH(1), .CNT_WIDTH(4)) dut1 (
    .clk_i(clk), .sync_rst_i(rst), .en_i(en), .in_valid_i(iv), .in_last_i(il),
    .inputs_i(inp1), .outputs_o(outp1), .out_valid_o(ov1), .out_last_o(ol1), .vec_count_o(cnt1));

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errs++;
      $error("FAIL %s t=%0d got=%h want=%h", tag, t, got, want);
    end
  endtask

  // One clock: drive, check against the model before the edge, then advance the model.
  task automatic cyc(input bit e, input bit r, input bit v, input bit l);
    logic [7:0] want;
    bit ev, el;
    en = e; rst = r; iv = v; il = l;
    inp = din; inp1[0] = din[0];
    #1;
    for (int i = 0; i < 4; i++) begin
      want = (i == 3) ? din[3] : (t >= 3 - i) ? hd[t-(3-i)][i] : 8'h00;
      chk($sformatf("col%0d", i), outp[i], want);
    end
    ev = (t >= 3) ? hv[t-3] : 1'b0;
    el = (t >= 3) ? hl[t-3] : 1'b0;
    chk("out_valid", {7'd0, ov}, {7'd0, ev});
    chk("out_last", {7'd0, ol}, {7'd0, el});
    chk("vec_count", {4'd0, cnt}, {4'd0, mcnt});
    chk("sa1_data", outp1[0], din[0]);
    chk("sa1_valid", {7'd0, ov1}, {7'd0, v});
    chk("sa1_last", {7'd0, ol1}, {7'd0, v & l});
    chk("sa1_count", {4'd0, cnt1}, {4'd0, mcnt1});
    @(posedge clk);
    if (r) begin
      t = 0; mcnt = 0; mcnt1 = 0;
    end else if (e) begin
      for (int i = 0; i < 4; i++) hd[t][i] = din[i];
      hv[t] = v; hl[t] = v & l;
      if (ev) mcnt = el ? 4'd0 : mcnt + 4'd1;
      if (v) mcnt1 = l ? 4'd0 : mcnt1 + 4'd1;
      t++;
    end
    @(negedge clk);
  endtask

  task automatic rand_din();
    for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
  endtask

  // n skewed vectors, column i of vector k = 16k+i+base; two EN=0 cycles before step 'stall'.
  task automatic stream(input int n, input logic [7:0] base, input bit lastf, input int stall);
    for (int c = 0; c < n + 4; c++) begin
      if (c == stall) repeat (2) begin
        rand_din();
        cyc(1'b0, 1'b0, 1'($urandom), 1'($urandom));
      end
      for (int i = 0; i < 4; i++)
        din[i] = (c - i >= 0 && c - i < n) ? 8'(16 * (c - i) + i + base) : 8'($urandom);
      cyc(1'b1, 1'b0, c < n, (c < n) ? (lastf && c == n - 1) : 1'($urandom));
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) din[i] = 8'h00;
    inp = din; inp1[0] = 8'h00;
    rst = 1;
    @(posedge clk); @(negedge clk);
    rand_din(); cyc(1'b0, 1'b1, 1'b1, 1'b1);
    rand_din(); cyc(1'b1, 1'b0, 1'b0, 1'b1);
    stream(1, 8'h10, 1'b0, -1);
    stream(6, 8'h00, 1'b1, -1);
    stream(6, 8'h00, 1'b1, 4);
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 4; i++) din[i] = (c == i) ? 8'(8'h40 + i) : 8'($urandom);
      cyc(1'b1, c == 2, c == 0, 1'b0);
    end
    chk("post_rst_count", {4'd0, cnt}, 8'h00);
    stream(17, 8'h00, 1'b0, -1);
    stream(3, 8'h05, 1'b1, -1);
    for (int c = 0; c < 120; c++) begin
      rand_din();
      cyc(($urandom % 4) != 0, ($urandom % 50) == 0, 1'($urandom), ($urandom % 4) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
